pwm_cfg_sequencer: RTL and testbench

APB master that replays a programmable table of (address, data) register writes into the pwm_controller APB slave on a single start command. Lets software or a system FSM reconfigure all PWM channels as one burst. The burst can optionally be aligned to the PWM period boundary (sync pulse). It sits between a local config table interface and the pwm_controller APB port, and reports completion, error and abort status.

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_cfg_table.sv | 32 +++
 rtl/pwm_cfg_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_pwm_cfg_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and register map for the PWM configuration sequencer and its benches.
package pwm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SYNC,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_SLV  = 2'b01,
    ERR_TMO  = 2'b10,
    ERR_ABT  = 2'b11
  } err_code_e;

  // pwm_controller register offsets
  localparam logic [11:0] PWM_CTRL     = 12'h000;
  localparam logic [11:0] PWM_STATUS   = 12'h004;
  localparam logic [11:0] PWM_PRESCALE = 12'h008;
  localparam logic [11:0] PWM_PERIOD   = 12'h010;
  localparam logic [11:0] PWM_DUTY0    = 12'h014;
  localparam logic [11:0] PWM_DUTY1    = 12'h018;
  localparam logic [11:0] PWM_DUTY2    = 12'h01C;
  localparam logic [11:0] PWM_DUTY3    = 12'h020;

endpackage

// File: rtl/pwm_cfg_table.sv
// Configuration table: DEPTH (address, data) pairs, one write port, one async read port.
module pwm_cfg_table #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned IDX_W  = $clog2(DEPTH),
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  // Contents are deliberately not reset; software reloads after power-up.
  always_ff @(posedge clk) begin
    if (we) begin
      addr_mem[wr_idx] <= wr_addr;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_addr = addr_mem[rd_idx];
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// APB master replaying the configuration table into the pwm_controller as one burst.
module pwm_cfg_sequencer
  import pwm_pkg::*;
#(
  parameter  int unsigned DEPTH   = 16,
  parameter  int unsigned ADDR_W  = 12,
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned IDX_W   = $clog2(DEPTH)
) (
  input  logic              pclk_i,
  input  logic              preset_n_i,
  input  logic              tbl_we_i,
  input  logic [IDX_W-1:0]  tbl_idx_i,
  input  logic [ADDR_W-1:0] tbl_addr_i,
  input  logic [DATA_W-1:0] tbl_data_i,
  input  logic              start_i,
  input  logic [IDX_W:0]    count_i,
  input  logic              align_i,
  input  logic              abort_i,
  input  logic              sync_i,
  output logic              m_psel_o,
  output logic              m_penable_o,
  output logic              m_pwrite_o,
  output logic [ADDR_W-1:0] m_paddr_o,
  output logic [DATA_W-1:0] m_pwdata_o,
  input  logic              m_pready_i,
  input  logic              m_pslverr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [IDX_W-1:0]  err_idx_o
);

  localparam int unsigned    TMO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

  seq_state_e        state;
  err_code_e         err_code;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W:0]    cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              abort_pend;
  logic [IDX_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              last;
  logic              tmo_hit;

  // Read port looks one entry ahead while in ACCESS so the next SETUP loads without a bubble.
  assign rd_idx  = (state == ST_ACCESS) ? idx + IDX_W'(1) : '0;
  assign last    = ({1'b0, idx} == cnt - (IDX_W + 1)'(1));
  assign tmo_hit = (TIMEOUT != 0) && ((32'(tmo_cnt) + 32'd1) == TIMEOUT);

  assign busy_o     = (state != ST_IDLE);
  assign m_pwrite_o = m_psel_o;
  assign err_code_o = err_code;

  pwm_cfg_table #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_table (
    .clk    (pclk_i),
    .we     (tbl_we_i && (state == ST_IDLE)),
    .wr_idx (tbl_idx_i),
    .wr_addr(tbl_addr_i),
    .wr_data(tbl_data_i),
    .rd_idx (rd_idx),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state       <= ST_IDLE;
      err_code    <= ERR_NONE;
      idx         <= '0;
      cnt         <= '0;
      tmo_cnt     <= '0;
      abort_pend  <= 1'b0;
      m_psel_o    <= 1'b0;
      m_penable_o <= 1'b0;
      m_paddr_o   <= '0;
      m_pwdata_o  <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_idx_o   <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_i) begin
            cnt        <= (count_i > DEPTH_C) ? DEPTH_C : count_i;
            idx        <= '0;
            abort_pend <= 1'b0;
            err_o      <= 1'b0;
            err_code   <= ERR_NONE;
            err_idx_o  <= '0;
            if (count_i == '0) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else if (align_i) begin
              state <= ST_WAIT_SYNC;
            end else begin
              state      <= ST_SETUP;
              m_psel_o   <= 1'b1;
              m_paddr_o  <= rd_addr;
              m_pwdata_o <= rd_data;
            end
          end
        end
        ST_WAIT_SYNC: begin
          if (abort_i) begin
            state     <= ST_DONE;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
            err_code  <= ERR_ABT;
            err_idx_o <= '0;
          end else if (sync_i) begin
            state      <= ST_SETUP;
            m_psel_o   <= 1'b1;
            m_paddr_o  <= rd_addr;
            m_pwdata_o <= rd_data;
          end
        end
        ST_SETUP: begin
          state       <= ST_ACCESS;
          m_penable_o <= 1'b1;
          tmo_cnt     <= '0;
          if (abort_i) abort_pend <= 1'b1;
        end
        ST_ACCESS: begin
          if (abort_i) abort_pend <= 1'b1;
          if (m_pready_i) begin
            m_psel_o    <= 1'b0;
            m_penable_o <= 1'b0;
            if (m_pslverr_i) begin
              state     <= ST_DONE;
              done_o    <= 1'b1;
              err_o     <= 1'b1;
              err_code  <= ERR_SLV;
              err_idx_o <= idx;
            end else if (last) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else if (abort_i || abort_pend) begin
              state     <= ST_DONE;
              done_o    <= 1'b1;
              err_o     <= 1'b1;
              err_code  <= ERR_ABT;
              err_idx_o <= idx + IDX_W'(1);
            end else begin
              state      <= ST_SETUP;
              idx        <= idx + IDX_W'(1);
              m_psel_o   <= 1'b1;
              m_paddr_o  <= rd_addr;
              m_pwdata_o <= rd_data;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_hit) begin
              state       <= ST_DONE;
              done_o      <= 1'b1;
              m_psel_o    <= 1'b0;
              m_penable_o <= 1'b0;
              err_o       <= 1'b1;
              err_code    <= ERR_TMO;
              err_idx_o   <= idx;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Scoreboard bench for pwm_cfg_sequencer: randomized bursts against a transaction-level model.
module tb_pwm_cfg_sequencer;
  import pwm_pkg::*;

  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int TMO   = 4;

  logic              pclk_i = 1'b0;
  logic              preset_n_i = 1'b0;
  logic              tbl_we_i = 1'b0;
  logic [IDX_W-1:0]  tbl_idx_i = '0;
  logic [11:0]       tbl_addr_i = '0;
  logic [31:0]       tbl_data_i = '0;
  logic              start_i = 1'b0;
  logic [IDX_W:0]    count_i = '0;
  logic              align_i = 1'b0;
  logic              abort_i;
  logic              sync_i = 1'b0;
  logic              m_psel_o, m_penable_o, m_pwrite_o;
  logic [11:0]       m_paddr_o;
  logic [31:0]       m_pwdata_o;
  logic              m_pready_i = 1'b0;
  logic              m_pslverr_i = 1'b0;
  logic              busy_o, done_o, err_o;
  logic [1:0]        err_code_o;
  logic [IDX_W-1:0]  err_idx_o;
  logic              abort_stim = 1'b0;
  logic              abort_resp = 1'b0;

  assign abort_i = abort_stim | abort_resp;

  always #5 pclk_i = ~pclk_i;

  pwm_cfg_sequencer #(
    .DEPTH  (DEPTH),
    .ADDR_W (12),
    .DATA_W (32),
    .TIMEOUT(TMO)
  ) dut (
    .pclk_i     (pclk_i),
    .preset_n_i (preset_n_i),
    .tbl_we_i   (tbl_we_i),
    .tbl_idx_i  (tbl_idx_i),
    .tbl_addr_i (tbl_addr_i),
    .tbl_data_i (tbl_data_i),
    .start_i    (start_i),
    .count_i    (count_i),
    .align_i    (align_i),
    .abort_i    (abort_i),
    .sync_i     (sync_i),
    .m_psel_o   (m_psel_o),
    .m_penable_o(m_penable_o),
    .m_pwrite_o (m_pwrite_o),
    .m_paddr_o  (m_paddr_o),
    .m_pwdata_o (m_pwdata_o),
    .m_pready_i (m_pready_i),
    .m_pslverr_i(m_pslverr_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_code_o (err_code_o),
    .err_idx_o  (err_idx_o)
  );

  typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int code; int idx; int lat; } cmp_t;

  wr_t  exp_wr[$];
  cmp_t exp_cmp[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   edge_cnt = 0;
  int   sedge = 0;
  int   done_cnt = 0;

  logic [11:0] m_addr [DEPTH];
  logic [31:0] m_data [DEPTH];
  int          wait_plan [64];
  bit          err_plan [64];
  int          abort_k = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_event(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: got %0h expected no such event", name, act);
  endtask

  always @(posedge pclk_i) edge_cnt++;

  // APB slave responder: per-transfer wait states, slave errors and an abort pulse in a chosen SETUP.
  int acc = 0;
  int xfer_k = 0;
  bit hs_pending = 0;
  always @(posedge pclk_i) begin
    #1;
    if (hs_pending) begin xfer_k++; acc = 0; hs_pending = 0; end
    if (!busy_o) xfer_k = 0;
    if (!(m_psel_o && m_penable_o)) acc = 0;
    abort_resp  = m_psel_o && !m_penable_o && (xfer_k == abort_k);
    m_pready_i  = 1'b0;
    m_pslverr_i = 1'b0;
    if (m_psel_o && m_penable_o) begin
      if (acc >= wait_plan[xfer_k]) begin
        m_pready_i  = 1'b1;
        m_pslverr_i = err_plan[xfer_k];
        hs_pending  = 1;
      end
      acc++;
    end
  end

  // Monitor: pops expected writes on each APB handshake and expected status on each done pulse.
  logic [11:0] su_addr = '0;
  logic [31:0] su_data = '0;
  bit          unstable = 0;
  bit          done_prev = 0;
  always @(negedge pclk_i) begin
    wr_t  w;
    cmp_t c;
    if (m_psel_o && !m_penable_o) begin
      su_addr  = m_paddr_o;
      su_data  = m_pwdata_o;
      unstable = 0;
    end
    if (m_psel_o && m_penable_o) begin
      if (m_paddr_o !== su_addr || m_pwdata_o !== su_data || m_pwrite_o !== 1'b1) unstable = 1;
      if (m_pready_i) begin
        if (exp_wr.size() == 0) fail_event("unexpected_write", m_paddr_o);
        else begin
          w = exp_wr.pop_front();
          chk("apb_addr", m_paddr_o, w.addr);
          chk("apb_data", m_pwdata_o, w.data);
          chk("apb_stable", unstable, 0);
        end
      end
    end
    if (done_o) begin
      done_cnt++;
      if (done_prev) fail_event("done_pulse_width", done_cnt);
      else if (exp_cmp.size() == 0) fail_event("unexpected_done", err_code_o);
      else begin
        c = exp_cmp.pop_front();
        chk("err_flag", err_o, (c.code != 0));
        chk("err_code", err_code_o, c.code);
        chk("err_idx", err_idx_o, c.idx);
        chk("done_latency", edge_cnt - sedge, c.lat);
        chk("writes_drained", exp_wr.size(), 0);
      end
    end
    done_prev = done_o;
  end

  task automatic clear_plans();
    for (int i = 0; i < 64; i++) begin
      wait_plan[i] = 0;
      err_plan[i]  = 0;
    end
    abort_k = -1;
  endtask

  task automatic tbl_write(input int i, input logic [11:0] a, input logic [31:0] d);
    @(negedge pclk_i);
    tbl_we_i   = 1'b1;
    tbl_idx_i  = IDX_W'(i);
    tbl_addr_i = a;
    tbl_data_i = d;
    m_addr[i]  = a;
    m_data[i]  = d;
    @(negedge pclk_i);
    tbl_we_i = 1'b0;
  endtask

  // Reference: walk the table entry by entry, summing cycle cost and stopping on the first outcome.
  task automatic run_burst(input int cnt, input bit al, input int s, input int wa, input bit poke);
    int n, lat, code, eidx, tmax, d0;
    bit ws_abort;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    code = 0; eidx = 0; lat = 0;
    ws_abort = al && (wa != 0) && (s == 0 || wa <= s);
    if (n != 0) begin
      if (ws_abort) begin
        code = 3; lat = wa;
      end else begin
        lat = al ? s : 0;
        for (int k = 0; k < n; k++) begin
          if (wait_plan[k] >= TMO) begin lat += 1 + TMO; code = 2; eidx = k; break; end
          lat += 2 + wait_plan[k];
          exp_wr.push_back('{m_addr[k], m_data[k]});
          if (err_plan[k]) begin code = 1; eidx = k; break; end
          if (k == n - 1) break;
          if (abort_k == k) begin code = 3; eidx = k + 1; break; end
        end
      end
    end
    exp_cmp.push_back('{code, eidx, lat});
    d0 = done_cnt;
    @(negedge pclk_i);
    start_i = 1'b1;
    count_i = (IDX_W + 1)'(cnt);
    align_i = al;
    sedge   = edge_cnt + 1;
    @(negedge pclk_i);
    start_i = 1'b0;
    tmax = al ? ((s > wa) ? s : wa) : 0;
    for (int t = 1; t <= tmax; t++) begin
      sync_i     = (t == s);
      abort_stim = (t == wa) && ws_abort;
      @(negedge pclk_i);
    end
    sync_i = 1'b0;
    abort_stim = 1'b0;
    if (poke) begin
      for (int i = 0; i < 4; i++) begin
        tbl_we_i   = 1'b1;
        tbl_idx_i  = IDX_W'(i);
        tbl_addr_i = 12'($urandom);
        tbl_data_i = $urandom;
        start_i    = 1'b1;
        @(negedge pclk_i);
      end
      tbl_we_i = 1'b0;
      start_i  = 1'b0;
    end
    for (int w = 0; w < 400 && done_cnt == d0; w++) @(negedge pclk_i);
    if (done_cnt == d0) fail_event("done_timeout", edge_cnt);
    @(negedge pclk_i);
    @(negedge pclk_i);
    chk("err_hold", err_o, (code != 0));
    chk("err_code_hold", err_code_o, code);
  endtask

  initial begin
    int d0, al, s, wa;
    clear_plans();
    repeat (2) @(negedge pclk_i);
    chk("rst_psel", m_psel_o, 0);
    chk("rst_penable", m_penable_o, 0);
    chk("rst_pwrite", m_pwrite_o, 0);
    chk("rst_paddr", m_paddr_o, 0);
    chk("rst_pwdata", m_pwdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", {err_o, err_code_o, err_idx_o}, 0);
    preset_n_i = 1'b1;

    tbl_write(0, PWM_CTRL, 32'h1);
    tbl_write(1, PWM_PERIOD, 32'h3E8);
    tbl_write(2, PWM_DUTY0, 32'h1F4);
    run_burst(3, 0, 0, 0, 0);
    wait_plan[1] = 2;   run_burst(3, 0, 0, 0, 0); clear_plans();
    err_plan[1] = 1;    run_burst(3, 0, 0, 0, 0); clear_plans();
    wait_plan[0] = 100; run_burst(3, 0, 0, 0, 0); clear_plans();
    run_burst(3, 1, 20, 0, 0);
    run_burst(3, 1, 0, 5, 0);
    run_burst(3, 1, 3, 3, 0);
    run_burst(0, 0, 0, 0, 0);
    abort_k = 0; run_burst(3, 0, 0, 0, 0); clear_plans();
    abort_k = 2; run_burst(3, 0, 0, 0, 0); clear_plans();

    for (int i = 0; i < DEPTH; i++) tbl_write(i, 12'($urandom), $urandom);
    for (int i = 0; i < 8; i++) wait_plan[i] = 2;
    run_burst(8, 0, 0, 0, 1);
    clear_plans();
    run_burst(8, 0, 0, 0, 0);
    run_burst(20, 0, 0, 0, 0);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 2) == 0) tbl_write($urandom_range(0, DEPTH - 1), 12'($urandom), $urandom);
      for (int k = 0; k < DEPTH; k++) begin
        wait_plan[k] = ($urandom_range(0, 15) == 0) ? TMO + 2 : $urandom_range(0, 3);
        err_plan[k]  = ($urandom_range(0, 11) == 0);
      end
      abort_k = ($urandom_range(0, 5) == 0) ? $urandom_range(0, DEPTH - 1) : -1;
      al = $urandom_range(0, 1);
      s  = (al != 0) ? $urandom_range(1, 6) : 0;
      wa = (al != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      run_burst($urandom_range(0, 20), al[0], s, wa, 0);
    end
    clear_plans();

    // Reset in the middle of a stalled transfer: outputs clear at once and no done follows.
    wait_plan[0] = 100;
    @(negedge pclk_i);
    start_i = 1'b1; count_i = 5'd2; align_i = 1'b0;
    @(negedge pclk_i);
    start_i = 1'b0;
    repeat (3) @(negedge pclk_i);
    d0 = done_cnt;
    #2 preset_n_i = 1'b0;
    #1;
    chk("midrst_psel", m_psel_o, 0);
    chk("midrst_penable", m_penable_o, 0);
    chk("midrst_busy", busy_o, 0);
    repeat (3) @(negedge pclk_i);
    preset_n_i = 1'b1;
    repeat (10) @(negedge pclk_i);
    chk("midrst_no_done", done_cnt, d0);
    clear_plans();

    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("cmp_queue_empty", exp_cmp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_cnt);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
